// File: rtl/motoro3_pkg.sv
// Shared types and defaults for the 3-phase step generator speed-ramp controller.
package motoro3_pkg;

  localparam int unsigned PERIOD_W = 25;

  typedef logic [PERIOD_W-1:0] period_t;

  localparam period_t DEFAULT_START_PERIOD = 25'd1_666_667;
  localparam period_t DEFAULT_MIN_PERIOD   = 25'd1_667;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACCEL    = 3'd1,
    RUN      = 3'd2,
    DECEL    = 3'd3,
    STOPWAIT = 3'd4
  } ctrl_state_e;

  function automatic period_t clamp_target(input period_t cmd, input period_t lo, input period_t hi);
    if (cmd < lo) return lo;
    if (cmd > hi) return hi;
    return cmd;
  endfunction

endpackage

// File: rtl/motoro3_ramp_calc.sv
// Combinational geometric ramp step: moves the period toward the target by period>>RAMP_SHIFT (at least 1).
module motoro3_ramp_calc
  import motoro3_pkg::*;
#(
  parameter int unsigned RAMP_SHIFT = 4
) (
  input  period_t period,
  input  period_t tgt,
  input  logic    decel,
  output period_t next_period,
  output logic    reached
);

  period_t             delta;
  period_t             diff;
  logic [PERIOD_W:0]   sum;

  always_comb begin
    delta = period >> RAMP_SHIFT;
    if (delta == '0) delta = period_t'(1);
    diff = period - delta;
    sum  = {1'b0, period} + {1'b0, delta};
    // Raw add/subtract results are compared against the target before clamping, so no wrap leaks out.
    if (decel) begin
      next_period = (sum > {1'b0, tgt}) ? tgt : sum[PERIOD_W-1:0];
    end else begin
      next_period = (period < delta || diff < tgt) ? tgt : diff;
    end
    reached = (next_period == tgt);
  end

endmodule

// File: rtl/motoro3_ramp_ctrl.sv
// Speed-ramp scheduler: accepts run/stop commands and ramps the step generator's reload period per step event.
module motoro3_ramp_ctrl
  import motoro3_pkg::*;
#(
  parameter period_t     START_PERIOD = DEFAULT_START_PERIOD,
  parameter period_t     MIN_PERIOD   = DEFAULT_MIN_PERIOD,
  parameter int unsigned RAMP_SHIFT   = 4
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                cmdValid,
  output logic                cmdReady,
  input  logic                cmdRun,
  input  logic [PERIOD_W-1:0] cmdPeriod,
  input  logic                m3cntLast1,
  output logic                m3start,
  output logic [PERIOD_W-1:0] m3reload,
  output logic                atSpeed,
  output logic                rampBusy,
  output logic [2:0]          ctrlState
);

  ctrl_state_e state, state_n;
  period_t     reload_q, reload_n;
  period_t     tgt, tgt_n;
  logic        start_q, start_n;
  logic        stop_pending, stop_pending_n;
  logic        last1_d;
  logic        at_speed_q, ramp_busy_q, cmd_ready_q;

  logic        accept;
  logic        step_evt;
  period_t     cmd_tgt;
  period_t     calc_next;
  logic        calc_reached;

  assign accept   = cmdValid & cmd_ready_q;
  assign step_evt = m3cntLast1 & ~last1_d & start_q;
  assign cmd_tgt  = clamp_target(period_t'(cmdPeriod), MIN_PERIOD, START_PERIOD);

  motoro3_ramp_calc #(.RAMP_SHIFT(RAMP_SHIFT)) u_calc (
    .period      (reload_q),
    .tgt         (tgt),
    .decel       (state == DECEL),
    .next_period (calc_next),
    .reached     (calc_reached)
  );

  always_comb begin
    state_n        = state;
    reload_n       = reload_q;
    tgt_n          = tgt;
    start_n        = start_q;
    stop_pending_n = stop_pending;
    unique case (state)
      IDLE: begin
        if (accept && cmdRun) begin
          reload_n       = START_PERIOD;
          start_n        = 1'b1;
          tgt_n          = cmd_tgt;
          stop_pending_n = 1'b0;
          state_n        = (cmd_tgt < START_PERIOD) ? ACCEL : RUN;
        end
      end
      ACCEL, RUN, DECEL: begin
        // A command accepted on a step event takes priority; that step's period update is dropped.
        if (accept) begin
          if (cmdRun) begin
            tgt_n          = cmd_tgt;
            stop_pending_n = 1'b0;
            if (cmd_tgt < reload_q)      state_n = ACCEL;
            else if (cmd_tgt > reload_q) state_n = DECEL;
            else                         state_n = RUN;
          end else begin
            tgt_n          = START_PERIOD;
            stop_pending_n = 1'b1;
            state_n        = (reload_q < START_PERIOD) ? DECEL : STOPWAIT;
          end
        end else if (step_evt && state != RUN) begin
          reload_n = calc_next;
          if (calc_reached) begin
            if (state == DECEL && stop_pending) state_n = STOPWAIT;
            else                                state_n = RUN;
          end
        end
      end
      STOPWAIT: begin
        if (step_evt) begin
          start_n        = 1'b0;
          stop_pending_n = 1'b0;
          state_n        = IDLE;
        end
      end
      default: begin
        state_n  = IDLE;
        start_n  = 1'b0;
        reload_n = START_PERIOD;
        tgt_n    = START_PERIOD;
      end
    endcase
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state        <= IDLE;
      reload_q     <= START_PERIOD;
      tgt          <= START_PERIOD;
      start_q      <= 1'b0;
      stop_pending <= 1'b0;
      last1_d      <= 1'b0;
      at_speed_q   <= 1'b0;
      ramp_busy_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
    end else begin
      state        <= state_n;
      reload_q     <= reload_n;
      tgt          <= tgt_n;
      start_q      <= start_n;
      stop_pending <= stop_pending_n;
      last1_d      <= m3cntLast1;
      at_speed_q   <= (state_n == RUN);
      ramp_busy_q  <= (state_n == ACCEL) || (state_n == DECEL);
      cmd_ready_q  <= (state_n != STOPWAIT);
    end
  end

  assign m3start   = start_q;
  assign m3reload  = reload_q;
  assign atSpeed   = at_speed_q;
  assign rampBusy  = ramp_busy_q;
  assign cmdReady  = cmd_ready_q;
  assign ctrlState = state;

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// Directed bench for motoro3_ramp_ctrl with START=1000, MIN=100, shift 2; step events driven directly.
module tb_motoro3_ramp_ctrl;

  logic        clk = 1'b0;
  logic        nRst;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdRun;
  logic [24:0] cmdPeriod;
  logic        m3cntLast1;
  logic        m3start;
  logic [24:0] m3reload;
  logic        atSpeed;
  logic        rampBusy;
  logic [2:0]  ctrlState;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  motoro3_ramp_ctrl #(
    .START_PERIOD(25'd1000),
    .MIN_PERIOD  (25'd100),
    .RAMP_SHIFT  (2)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .cmdValid   (cmdValid),
    .cmdReady   (cmdReady),
    .cmdRun     (cmdRun),
    .cmdPeriod  (cmdPeriod),
    .m3cntLast1 (m3cntLast1),
    .m3start    (m3start),
    .m3reload   (m3reload),
    .atSpeed    (atSpeed),
    .rampBusy   (rampBusy),
    .ctrlState  (ctrlState)
  );

  // DUT updates on the falling edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic run, input logic [24:0] period, input logic evt);
    cmdValid   = 1'b1;
    cmdRun     = run;
    cmdPeriod  = period;
    m3cntLast1 = evt;
    tick();
    cmdValid   = 1'b0;
    m3cntLast1 = 1'b0;
  endtask

  task automatic step_pulse();
    m3cntLast1 = 1'b1;
    tick();
    m3cntLast1 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    nRst = 1'b0; cmdValid = 1'b0; cmdRun = 1'b0; cmdPeriod = '0; m3cntLast1 = 1'b0;
    repeat (3) tick();
    @(posedge clk);
    nRst = 1'b1;
    repeat (10) tick();
    vectors++; if (m3start !== 1'b0) begin miscompares++; $display("FAIL reset_m3start got %0b want 0", m3start); end
    vectors++; if (m3reload !== 25'd1000) begin miscompares++; $display("FAIL reset_reload got %0d want 1000", m3reload); end
    vectors++; if (cmdReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", cmdReady); end
    vectors++; if (ctrlState !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", ctrlState); end
    vectors++; if ({atSpeed, rampBusy} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", {atSpeed, rampBusy}); end
  endtask

  task automatic test_idle_stop();
    send_cmd(1'b0, 25'd500, 1'b0);
    step_pulse();
    vectors++; if ({m3start, ctrlState} !== 4'b0_000) begin miscompares++; $display("FAIL idle_stop got start=%0b state=%0d want 0/0", m3start, ctrlState); end
    vectors++; if (m3reload !== 25'd1000) begin miscompares++; $display("FAIL idle_stop_reload got %0d want 1000", m3reload); end
  endtask

  task automatic test_accel();
    logic [24:0] exp_seq [3] = '{25'd750, 25'd563, 25'd500};
    send_cmd(1'b1, 25'd500, 1'b0);
    vectors++; if (m3start !== 1'b1) begin miscompares++; $display("FAIL accel_start got %0b want 1", m3start); end
    vectors++; if (m3reload !== 25'd1000) begin miscompares++; $display("FAIL accel_init_reload got %0d want 1000", m3reload); end
    vectors++; if ({ctrlState, rampBusy, atSpeed} !== 5'b001_1_0) begin miscompares++; $display("FAIL accel_state got %0d busy=%0b spd=%0b want 1/1/0", ctrlState, rampBusy, atSpeed); end
    for (int i = 0; i < 3; i++) begin
      step_pulse();
      vectors++; if (m3reload !== exp_seq[i]) begin miscompares++; $display("FAIL accel_reload[%0d] got %0d want %0d", i, m3reload, exp_seq[i]); end
      if (i == 1) begin
        vectors++; if (atSpeed !== 1'b0) begin miscompares++; $display("FAIL accel_early_atspeed got %0b want 0", atSpeed); end
      end
    end
    vectors++; if ({ctrlState, atSpeed, rampBusy} !== 5'b010_1_0) begin miscompares++; $display("FAIL accel_run got %0d spd=%0b busy=%0b want 2/1/0", ctrlState, atSpeed, rampBusy); end
  endtask

  task automatic test_stop();
    logic [24:0] exp_seq [4] = '{25'd625, 25'd781, 25'd976, 25'd1000};
    send_cmd(1'b0, 25'd0, 1'b0);
    vectors++; if ({ctrlState, atSpeed} !== 4'b011_0) begin miscompares++; $display("FAIL stop_decel got %0d spd=%0b want 3/0", ctrlState, atSpeed); end
    for (int i = 0; i < 4; i++) begin
      step_pulse();
      vectors++; if (m3reload !== exp_seq[i]) begin miscompares++; $display("FAIL stop_reload[%0d] got %0d want %0d", i, m3reload, exp_seq[i]); end
    end
    vectors++; if ({ctrlState, cmdReady, m3start} !== 5'b100_0_1) begin miscompares++; $display("FAIL stopwait got %0d rdy=%0b start=%0b want 4/0/1", ctrlState, cmdReady, m3start); end
    send_cmd(1'b1, 25'd500, 1'b0);
    vectors++; if (ctrlState !== 3'd4) begin miscompares++; $display("FAIL stopwait_ignore got %0d want 4", ctrlState); end
    step_pulse();
    vectors++; if ({m3start, ctrlState, cmdReady} !== 5'b0_000_1) begin miscompares++; $display("FAIL stop_done got start=%0b state=%0d rdy=%0b want 0/0/1", m3start, ctrlState, cmdReady); end
  endtask

  task automatic test_clamp();
    logic [24:0] acc_seq [9]  = '{25'd750, 25'd563, 25'd423, 25'd318, 25'd239, 25'd180, 25'd135, 25'd102, 25'd100};
    logic [24:0] dec_seq [11] = '{25'd125, 25'd156, 25'd195, 25'd243, 25'd303, 25'd378, 25'd472, 25'd590, 25'd737, 25'd921, 25'd1000};
    send_cmd(1'b1, 25'd20, 1'b0);
    // Hold the step input high three cycles: only its rising edge counts.
    m3cntLast1 = 1'b1;
    repeat (3) tick();
    m3cntLast1 = 1'b0;
    tick();
    vectors++; if (m3reload !== acc_seq[0]) begin miscompares++; $display("FAIL edge_only got %0d want %0d", m3reload, acc_seq[0]); end
    for (int i = 1; i < 9; i++) begin
      step_pulse();
      vectors++; if (m3reload !== acc_seq[i]) begin miscompares++; $display("FAIL min_clamp[%0d] got %0d want %0d", i, m3reload, acc_seq[i]); end
    end
    vectors++; if (ctrlState !== 3'd2) begin miscompares++; $display("FAIL min_clamp_state got %0d want 2", ctrlState); end
    send_cmd(1'b1, 25'd5000, 1'b0);
    vectors++; if (ctrlState !== 3'd3) begin miscompares++; $display("FAIL max_clamp_decel got %0d want 3", ctrlState); end
    for (int i = 0; i < 11; i++) begin
      step_pulse();
      vectors++; if (m3reload !== dec_seq[i]) begin miscompares++; $display("FAIL max_clamp[%0d] got %0d want %0d", i, m3reload, dec_seq[i]); end
    end
    vectors++; if ({ctrlState, m3start, atSpeed} !== 5'b010_1_1) begin miscompares++; $display("FAIL max_clamp_run got %0d start=%0b spd=%0b want 2/1/1", ctrlState, m3start, atSpeed); end
  endtask

  task automatic test_cmd_with_step();
    logic [24:0] exp_seq [3] = '{25'd563, 25'd423, 25'd400};
    send_cmd(1'b1, 25'd500, 1'b0);
    step_pulse();
    vectors++; if ({m3reload, ctrlState} !== {25'd750, 3'd1}) begin miscompares++; $display("FAIL coll_pre got %0d/%0d want 750/1", m3reload, ctrlState); end
    send_cmd(1'b1, 25'd400, 1'b1);
    vectors++; if ({m3reload, ctrlState} !== {25'd750, 3'd1}) begin miscompares++; $display("FAIL coll_skip got %0d/%0d want 750/1", m3reload, ctrlState); end
    tick();
    for (int i = 0; i < 3; i++) begin
      step_pulse();
      vectors++; if (m3reload !== exp_seq[i]) begin miscompares++; $display("FAIL coll_reload[%0d] got %0d want %0d", i, m3reload, exp_seq[i]); end
    end
    vectors++; if (ctrlState !== 3'd2) begin miscompares++; $display("FAIL coll_run got %0d want 2", ctrlState); end
  endtask

  task automatic test_reset_mid_decel();
    logic [24:0] exp_seq [3] = '{25'd500, 25'd625, 25'd781};
    send_cmd(1'b0, 25'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_pulse();
      vectors++; if (m3reload !== exp_seq[i]) begin miscompares++; $display("FAIL rst_decel[%0d] got %0d want %0d", i, m3reload, exp_seq[i]); end
    end
    vectors++; if (ctrlState !== 3'd3) begin miscompares++; $display("FAIL rst_pre_state got %0d want 3", ctrlState); end
    @(posedge clk);
    nRst = 1'b0;
    #1;
    vectors++; if ({m3start, m3reload} !== {1'b0, 25'd1000}) begin miscompares++; $display("FAIL rst_async got start=%0b reload=%0d want 0/1000", m3start, m3reload); end
    vectors++; if ({ctrlState, cmdReady, rampBusy} !== 5'b000_1_0) begin miscompares++; $display("FAIL rst_async_state got %0d rdy=%0b busy=%0b want 0/1/0", ctrlState, cmdReady, rampBusy); end
    m3cntLast1 = 1'b1;
    tick();
    @(posedge clk);
    nRst = 1'b1;
    tick();
    m3cntLast1 = 1'b0;
    tick();
    vectors++; if ({m3start, ctrlState, m3reload} !== {1'b0, 3'd0, 25'd1000}) begin miscompares++; $display("FAIL rst_release got start=%0b state=%0d reload=%0d want 0/0/1000", m3start, ctrlState, m3reload); end
  endtask

  initial begin
    test_reset();
    test_idle_stop();
    test_accel();
    test_stop();
    test_clamp();
    test_cmd_with_step();
    test_reset_mid_decel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/motoro3_ramp_ctrl.md
Name: motoro3_ramp_ctrl

Overview:
Speed-ramp scheduler for the 3-phase step generator.
- Accepts run/stop commands with a target step period (clk cycles per step) over a valid/ready handshake.
- Drives the generator's m3start and per-step reload period.
- Ramps the period geometrically, one update per generator step event, so the motor accelerates and decelerates smoothly. It never jumps straight to the target speed.

Parameters:
START_PERIOD, 25'd1_666_667, period at start and at stop point (1 Hz electrical at 10 MHz, 6 steps).
MIN_PERIOD, 25'd1_667, fastest allowed period (1000 Hz electrical).
RAMP_SHIFT, 4, per-step change = period >> RAMP_SHIFT (minimum 1).

Ports:
clk  in  1  10 MHz clock; all state updates on falling edge, same as the step generator
nRst  in  1  asynchronous active-low reset
cmdValid  in  1  command present
cmdReady  out  1  command accepted when cmdValid & cmdReady at the clk falling edge
cmdRun  in  1  1 = run at cmdPeriod, 0 = stop
cmdPeriod  in  25  target period; ignored when cmdRun = 0
m3cntLast1  in  1  from step generator; last count of current step
m3start  out  1  run enable to step generator
m3reload  out  25  period for the generator to load at the next step boundary
atSpeed  out  1  running and m3reload == clamped target
rampBusy  out  1  state is ACCEL or DECEL
ctrlState  out  3  current state encoding, for debug

Behaviour:
- Reset (async, immediate): state IDLE, m3start=0, m3reload=START_PERIOD, atSpeed=0, rampBusy=0, cmdReady=1, internal target=START_PERIOD, stopPending=0, edge register=0.
- stepEvt = m3cntLast1 & ~m3cntLast1_d (rising edge, registered once). Used only while m3start=1.
- Target clamp on accept: tgt = min(max(cmdPeriod, MIN_PERIOD), START_PERIOD).
- Ramp delta: d = max(m3reload >> RAMP_SHIFT, 1). All arithmetic is 25-bit unsigned. Add/subtract results are compared before the clamp, so no wrap is possible.
- States:
  - IDLE (0):
    - Run cmd: m3reload=START_PERIOD, m3start=1 on the following edge.
    - Next state is ACCEL if tgt<START_PERIOD, else RUN.
    - Stop cmd in IDLE: accepted, no effect.
  - ACCEL (1): on stepEvt, m3reload = max(m3reload-d, tgt). When the result equals tgt, go to RUN.
  - RUN (2): m3reload held; atSpeed=1 (registered).
  - DECEL (3): on stepEvt, m3reload = min(m3reload+d, tgt). When the result equals tgt:
    - stopPending=0: go to RUN.
    - stopPending=1: go to STOPWAIT.
  - STOPWAIT (4): cmdReady=0. On the next stepEvt, m3start=0, stopPending=0, go to IDLE.
- Commands while running (ACCEL/RUN/DECEL; cmdReady=1):
  - Run cmd:
    - tgt<m3reload: ACCEL.
    - tgt>m3reload: DECEL.
    - Equal: RUN.
    - In all cases stopPending is cleared.
  - Stop cmd: tgt=START_PERIOD, stopPending=1.
    - m3reload<START_PERIOD: DECEL.
    - Otherwise: STOPWAIT.
- Simultaneous command accept and stepEvt in the same cycle: the command updates tgt and state; the period update for that stepEvt is skipped (m3reload unchanged).
- atSpeed deasserts on the same edge that leaves RUN.
- rampBusy is a registered decode of the state.
- Reset mid-ramp: immediate return to reset values, m3start drops asynchronously.

Decomposition:
- Package motoro3_pkg:
  - State encodings IDLE=0, ACCEL=1, RUN=2, DECEL=3, STOPWAIT=4.
  - Default START_PERIOD and MIN_PERIOD constants.
  - Period width 25.
- One sub-module, motoro3_ramp_calc: combinational next-period computation.
  - Inputs: current period, tgt, direction.
  - Output: next period, plus reached flag.
  - Unit-testable alone.

Test Plan:
Bench parameters: START_PERIOD=1000, MIN_PERIOD=100, RAMP_SHIFT=2; stepEvt driven directly.
- Reset, then idle 10 cycles -> m3start=0, m3reload=1000, cmdReady=1, ctrlState=0.
- Run cmd with cmdPeriod=500 -> m3start=1; successive stepEvts give m3reload 1000 -> 750 -> 563 -> 500; atSpeed=1 after the third stepEvt; ctrlState=2.
- From RUN at 500, stop cmd -> stepEvts give 625 -> 781 -> 976 -> 1000, then STOPWAIT with cmdReady=0; next stepEvt gives m3start=0, ctrlState=0.
- Run cmd with cmdPeriod=20 (below minimum) -> ramp ends at m3reload=100. Then run cmd with cmdPeriod=5000 -> DECEL ramp ends at 1000, state RUN (not stop).
- Run cmd with cmdPeriod=400 accepted in the same cycle as a stepEvt while in ACCEL at 750 -> m3reload stays 750 that cycle, next stepEvt gives 563.
- nRst pulsed low during DECEL at m3reload=781 -> m3start=0 and m3reload=1000 immediately; no stepEvt is counted on release.
